// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: accepts a WIDTH-bit word on valid/ready and emits it one bit per shift_en tick.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             last_cnt;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_cnt = (cnt == CNT_W'(1));
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // A new word may load in the same cycle the final bit of the previous one leaves.
  always_comb begin
    in_ready = (state == IDLE);
`ifdef PISO_SERIALIZER_PARITY_EN
    if (state == PARITY && shift_en) in_ready = 1'b1;
`else
    if (state == SHIFT && last_cnt && shift_en) in_ready = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: ;
        SHIFT: begin
          if (shift_en) begin
            out_bit   <= head_bit(sr);
            out_valid <= 1'b1;
            sr        <= shift_word(sr);
            cnt       <= cnt - CNT_W'(1);
            if (last_cnt) begin
`ifdef PISO_SERIALIZER_PARITY_EN
              state    <= PARITY;
`else
              out_last <= 1'b1;
              state    <= IDLE;
`endif
            end
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            out_bit   <= parity;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
      // Loading wins over the end-of-word transition so back-to-back words have no gap.
      if (accept) begin
        sr    <= in_data;
        cnt   <= CNT_W'(WIDTH);
        state <= SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity <= ^in_data;
`endif
      end
    end
  end

endmodule
